// File: rtl/sched_pkg.sv
// Shared definitions for the ingress round-robin burst scheduler and later egress arbiters.
package sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        XFER   = 2'd1,
        SETTLE = 2'd2
    } sched_state_e;

    // Width of a port index; a single-port arbiter still needs one bit.
    function automatic int port_w(input int n);
        return (n > 32'sd1) ? $clog2(n) : 32'sd1;
    endfunction

    function automatic bit burst_len_ok(input int burst_len, input int lvl_bit);
        return (burst_len >= 32'sd1) && (burst_len <= (32'sd1 << lvl_bit));
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requesting index after last_grant, wrapping.
module rr_pick
    import sched_pkg::*;
#(
    parameter  int PORT_NUM = 4,
    localparam int PW       = port_w(PORT_NUM)
) (
    input  logic [PORT_NUM-1:0] req,
    input  logic [PW-1:0]       last_grant,
    output logic [PW-1:0]       grant,
    output logic                any
);

    logic [PW-1:0] idx_s;

    // Scan farthest-to-nearest so the nearest requester after last_grant wins.
    always_comb begin
        grant = {PW{1'b0}};
        any   = 1'b0;
        idx_s = {PW{1'b0}};
        for (int k = PORT_NUM; k >= 1; k--) begin
            idx_s = PW'((int'(last_grant) + k) % PORT_NUM);
            if (req[idx_s]) begin
                grant = idx_s;
                any   = 1'b1;
            end else begin
                grant = grant;
                any   = any;
            end
        end
    end

endmodule

// File: rtl/fifo_rr_sched.sv
// Round-robin burst scheduler draining several dc_fifo read sides into one
// registered valid/ready stream tagged with port id and burst delimiters.
module fifo_rr_sched
    import sched_pkg::*;
#(
    parameter  int PORT_NUM  = 4,
    parameter  int DATA_BIT  = 16,
    parameter  int LVL_BIT   = 2,
    parameter  int BURST_LEN = 4,
    localparam int PW        = port_w(PORT_NUM)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [PORT_NUM-1:0]          fifo_empty,
    input  logic [PORT_NUM*LVL_BIT-1:0]  fifo_rd_cnt,
    input  logic [PORT_NUM*DATA_BIT-1:0] fifo_rd_data,
    output logic [PORT_NUM-1:0]          fifo_rd_en,
    output logic [DATA_BIT-1:0]          out_data,
    output logic [PW-1:0]                out_port,
    output logic                         out_sop,
    output logic                         out_eop,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         busy
);

    // An illegal burst length falls back to the FIFO depth rather than producing an unreachable eop.
    localparam int BURST_EFF = burst_len_ok(BURST_LEN, LVL_BIT) ? BURST_LEN : (32'sd1 << LVL_BIT);
    localparam int CW        = $clog2(BURST_EFF) + 1;

    sched_state_e          state_r, state_n;
    logic [PW-1:0]         grant_r, last_grant_r;
    logic [CW-1:0]         cnt_r, len_r;
    logic [DATA_BIT-1:0]   out_data_r;
    logic [PW-1:0]         out_port_r;
    logic                  out_sop_r, out_eop_r, out_valid_r, busy_r;

    logic [PW-1:0]         pick_s;
    logic                  any_s;
    logic [LVL_BIT-1:0]    lvl_s;
    logic [CW-1:0]         len_n_s;
    logic                  pop_s, last_s;
    logic [PORT_NUM-1:0]   rd_en_s;

    rr_pick #(.PORT_NUM(PORT_NUM)) u_rr_pick (
        .req        (~fifo_empty),
        .last_grant (last_grant_r),
        .grant      (pick_s),
        .any        (any_s)
    );

    // Burst length for the candidate port; a full FIFO wraps its level to zero.
    always_comb begin
        lvl_s = fifo_rd_cnt[pick_s*LVL_BIT +: LVL_BIT];
        if (lvl_s == {LVL_BIT{1'b0}}) begin
            len_n_s = CW'(BURST_EFF);
        end else if (int'(lvl_s) >= BURST_EFF) begin
            len_n_s = CW'(BURST_EFF);
        end else begin
            len_n_s = CW'(lvl_s);
        end
    end

    // Pop strobe: only in XFER, only when the granted FIFO has data and the output slot frees.
    always_comb begin
        pop_s   = (state_r == XFER) && !rst && !fifo_empty[grant_r] && (!out_valid_r || out_ready);
        last_s  = ((cnt_r + CW'(1)) == len_r);
        rd_en_s = {PORT_NUM{1'b0}};
        if (pop_s) begin
            rd_en_s[grant_r] = 1'b1;
        end else begin
            rd_en_s = {PORT_NUM{1'b0}};
        end
    end

    // Next-state logic.
    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE: begin
                if (any_s) state_n = XFER;
                else       state_n = IDLE;
            end
            XFER: begin
                if (pop_s && last_s) state_n = SETTLE;
                else                 state_n = XFER;
            end
            SETTLE:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State register and registered busy flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            busy_r  <= (state_n != IDLE);
        end
    end

    // Grant/length latch and the output register stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_r      <= {PW{1'b0}};
            last_grant_r <= PW'(PORT_NUM - 1);
            cnt_r        <= {CW{1'b0}};
            len_r        <= {CW{1'b0}};
            out_data_r   <= {DATA_BIT{1'b0}};
            out_port_r   <= {PW{1'b0}};
            out_sop_r    <= 1'b0;
            out_eop_r    <= 1'b0;
            out_valid_r  <= 1'b0;
        end else begin
            if ((state_r == IDLE) && any_s) begin
                grant_r      <= pick_s;
                last_grant_r <= pick_s;
                len_r        <= len_n_s;
                cnt_r        <= {CW{1'b0}};
            end
            if (pop_s) begin
                out_data_r  <= fifo_rd_data[grant_r*DATA_BIT +: DATA_BIT];
                out_port_r  <= grant_r;
                out_sop_r   <= (cnt_r == {CW{1'b0}});
                out_eop_r   <= last_s;
                out_valid_r <= 1'b1;
                cnt_r       <= cnt_r + CW'(1);
            end else if (out_valid_r && out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign fifo_rd_en = rd_en_s;
    assign out_data   = out_data_r;
    assign out_port   = out_port_r;
    assign out_sop    = out_sop_r;
    assign out_eop    = out_eop_r;
    assign out_valid  = out_valid_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_fifo_rr_sched.sv
// Scoreboard bench for fifo_rr_sched: behavioural FIFOs feed the scheduler,
// expected words are queued per test and compared on each output handshake.
module tb_fifo_rr_sched;

    localparam int PN = 4;
    localparam int DB = 16;
    localparam int LB = 2;
    localparam int BL = 4;
    localparam int PW = 2;

    typedef struct packed {
        logic [DB-1:0] d;
        logic [PW-1:0] p;
        logic          s;
        logic          e;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [PN-1:0]     fifo_empty;
    logic [PN*LB-1:0]  fifo_rd_cnt;
    logic [PN*DB-1:0]  fifo_rd_data;
    logic [PN-1:0]     fifo_rd_en;
    logic [DB-1:0]     out_data;
    logic [PW-1:0]     out_port;
    logic              out_sop, out_eop, out_valid, out_ready, busy;

    logic [DB-1:0]     mem [PN][16];
    int                wp [PN];
    int                rp [PN];
    int                pop_cnt [PN];
    logic [PN-1:0]     hide;
    logic [PN-1:0]     pops;
    exp_t              exp_q [$];
    int                checks = 0;
    int                errors = 0;
    int                cyc = 0;
    int                last_pop_cyc = 0;

    fifo_rr_sched #(.PORT_NUM(PN), .DATA_BIT(DB), .LVL_BIT(LB), .BURST_LEN(BL)) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_empty   (fifo_empty),
        .fifo_rd_cnt  (fifo_rd_cnt),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_en   (fifo_rd_en),
        .out_data     (out_data),
        .out_port     (out_port),
        .out_sop      (out_sop),
        .out_eop      (out_eop),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < PN; i++) begin
            int n;
            n = wp[i] - rp[i];
            fifo_empty[i]           = (n == 0) || hide[i];
            fifo_rd_cnt[i*LB +: LB] = n[LB-1:0];
            fifo_rd_data[i*DB +: DB] = (n > 0) ? mem[i][rp[i] % 16] : 16'h0000;
        end
    endtask

    function automatic logic [DB-1:0] word(input int port, input int seq);
        logic [3:0]  p4;
        logic [11:0] s12;
        p4  = port[3:0];
        s12 = seq[11:0];
        return {p4, s12};
    endfunction

    task automatic push_word(input int port, input int seq);
        mem[port][wp[port] % 16] = word(port, seq);
        wp[port]++;
        refresh();
    endtask

    task automatic expect_burst(input int port, input int first_seq, input int n);
        for (int k = 0; k < n; k++) begin
            exp_t e;
            e.d = word(port, first_seq + k);
            e.p = port[PW-1:0];
            e.s = (k == 0);
            e.e = (k == n - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic monitor();
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_underflow", exp_q.size(), 1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_eq("word", {out_data, out_port, out_sop, out_eop}, e);
            end
        end
        if (fifo_rd_en != 4'b0000) begin
            check_eq("rd_en_onehot", $onehot(fifo_rd_en), 1);
            check_eq("rd_en_nonempty", fifo_empty & fifo_rd_en, 4'b0000);
        end
    endtask

    // One clock: observe at negedge, capture pops just before posedge, update FIFOs after it.
    task automatic step();
        @(negedge clk);
        monitor();
        #4;
        pops = fifo_rd_en;
        @(posedge clk);
        if (pops != 4'b0000) last_pop_cyc = cyc;
        cyc++;
        #1;
        for (int i = 0; i < PN; i++) begin
            if (pops[i]) begin
                rp[i]++;
                pop_cnt[i]++;
            end
        end
        refresh();
    endtask

    task automatic wait_drain(input int budget);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || busy) && k < budget) begin
            step();
            k++;
        end
        check_eq("drain_in_budget", k < budget, 1);
        exp_q.delete();
    endtask

    task automatic wait_pops(input int port, input int n, input int budget);
        int k;
        k = 0;
        while (pop_cnt[port] < n && k < budget) begin
            step();
            k++;
        end
        check_eq("pops_in_budget", k < budget, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        hide = 4'b0000;
        for (int i = 0; i < PN; i++) pop_cnt[i] = 0;
        refresh();
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b1;
        hide = 4'b0000;
        pops = 4'b0000;
        for (int i = 0; i < PN; i++) begin
            wp[i] = 0;
            rp[i] = 0;
            pop_cnt[i] = 0;
        end
        refresh();
        step();
        step();
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_rd_en", fifo_rd_en, 4'b0000);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_data", out_data, 16'h0000);
        check_eq("rst_port", out_port, 2'd0);
        check_eq("rst_sop_eop", {out_sop, out_eop}, 2'b00);
        rst = 1'b0;

        // Single short burst on port 1: latency, framing and the idle gap.
        for (int k = 0; k < 3; k++) push_word(1, 1 + k);
        expect_burst(1, 1, 3);
        step();
        check_eq("t1_first_rd_en", fifo_rd_en, 4'b0010);
        check_eq("t1_no_valid_yet", out_valid, 0);
        step();
        check_eq("t1_first_valid", out_valid, 1);
        check_eq("t1_first_sop", out_sop, 1);
        wait_drain(30);
        check_eq("t1_idle_gap", cyc - last_pop_cyc, 2);

        // All ports full; port 0 refilled so it is granted again after port 3.
        do_reset();
        for (int p = 0; p < PN; p++)
            for (int k = 0; k < 4; k++) push_word(p, 16 * p + k);
        expect_burst(0, 0, 4);
        expect_burst(1, 16, 4);
        expect_burst(2, 32, 4);
        expect_burst(3, 48, 4);
        expect_burst(0, 4, 4);
        wait_pops(0, 4, 20);
        for (int k = 0; k < 4; k++) push_word(0, 4 + k);
        wait_drain(200);

        // Backpressure on the first word of a port 0 burst.
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) push_word(0, 256 + k);
        expect_burst(0, 256, 4);
        begin
            int k;
            k = 0;
            while (!out_valid && k < 10) begin
                step();
                k++;
            end
            check_eq("bp_valid_in_budget", k < 10, 1);
        end
        for (int k = 0; k < 5; k++) begin
            check_eq("bp_hold_data", out_data, word(0, 256));
            check_eq("bp_no_pop", fifo_rd_en, 4'b0000);
            step();
        end
        out_ready = 1'b1;
        wait_drain(30);

        // Granted FIFO goes empty mid-burst, then refills.
        do_reset();
        for (int k = 0; k < 4; k++) push_word(2, 512 + k);
        expect_burst(2, 512, 4);
        wait_pops(2, 2, 10);
        hide[2] = 1'b1;
        refresh();
        for (int k = 0; k < 4; k++) begin
            step();
            check_eq("mid_empty_no_pop", fifo_rd_en, 4'b0000);
            check_eq("mid_empty_busy", busy, 1);
        end
        hide[2] = 1'b0;
        refresh();
        wait_drain(30);

        // Reset after the second pop of a port 3 burst.
        do_reset();
        for (int k = 0; k < 4; k++) push_word(3, 768 + k);
        expect_burst(3, 768, 1);
        exp_q[0].e = 1'b0;
        wait_pops(3, 2, 10);
        rst = 1'b1;
        step();
        check_eq("rst_mid_valid", out_valid, 0);
        check_eq("rst_mid_rd_en", fifo_rd_en, 4'b0000);
        rst = 1'b0;
        check_eq("rst_mid_pops", pop_cnt[3], 2);
        for (int k = 0; k < 2; k++) push_word(0, 1024 + k);
        expect_burst(0, 1024, 2);
        expect_burst(3, 770, 2);
        wait_drain(60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
